// File: rtl/riscv_trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions, interrupts and MRET,
// sequences the CSR capture and mstatus updates, then redirects fetch.
module riscv_trap_ctrl #(
  parameter logic [31:0] MTVEC = 32'h8000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_tval_i,
  input  logic        boundary_i,
  input  logic [31:0] next_pc_i,
  input  logic        mret_i,
  input  logic        meip_i,
  input  logic        mtip_i,
  input  logic        mstatus_mie_i,
  input  logic        meie_i,
  input  logic        mtie_i,
  input  logic [31:0] mepc_i,
  output logic        stall_o,
  output logic        csr_we_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mcause_o,
  output logic [31:0] mtval_o,
  output logic        mstatus_enter_o,
  output logic        mstatus_exit_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o
);
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [XLEN-1:0] CAUSE_MTI = 32'h8000_0007;
  localparam logic [XLEN-1:0] PC_MASK   = ~XLEN'(1);

  typedef enum logic [1:0] {IDLE, ENTER, TVEC, EXIT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            csr_we_q, csr_we_d, enter_q, enter_d, exit_q, exit_d;
  logic            redirect_q, redirect_d, busy_q, busy_d;
  logic            idle_c, take_exc_c, take_mret_c, take_ext_c, take_tmr_c;
  logic [XLEN-1:0] exc_mtval_c;

  // Fixed priority: exception > MRET > external > timer; only sampled in IDLE
  assign idle_c      = (state_q == IDLE);
  assign take_exc_c  = idle_c & exc_valid_i;
  assign take_mret_c = idle_c & ~exc_valid_i & mret_i;
  assign take_ext_c  = idle_c & ~exc_valid_i & ~mret_i & boundary_i & mstatus_mie_i
                     & meie_i & meip_i;
  assign take_tmr_c  = idle_c & ~exc_valid_i & ~mret_i & boundary_i & mstatus_mie_i
                     & mtie_i & mtip_i & ~(meie_i & meip_i);

  assign stall_o = ~idle_c | take_exc_c | take_mret_c | take_ext_c | take_tmr_c;

  always_comb begin
    case (exc_cause_i)
      32'd0, 32'd1, 32'd2, 32'd4, 32'd5, 32'd6, 32'd7: exc_mtval_c = exc_tval_i;
      32'd3:   exc_mtval_c = exc_pc_i;
      default: exc_mtval_c = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    csr_we_d      = 1'b0;
    enter_d       = 1'b0;
    exit_d        = 1'b0;
    redirect_d    = 1'b0;
    redirect_pc_d = '0;
    case (state_q)
      IDLE: begin
        if (take_exc_c) begin
          state_d  = ENTER;
          mepc_d   = exc_pc_i & PC_MASK;
          mcause_d = exc_cause_i;
          mtval_d  = exc_mtval_c;
        end else if (take_mret_c) begin
          state_d = EXIT;
        end else if (take_ext_c) begin
          state_d  = ENTER;
          mepc_d   = next_pc_i & PC_MASK;
          mcause_d = CAUSE_MEI;
          mtval_d  = '0;
        end else if (take_tmr_c) begin
          state_d  = ENTER;
          mepc_d   = next_pc_i & PC_MASK;
          mcause_d = CAUSE_MTI;
          mtval_d  = '0;
        end
      end
      ENTER:   state_d = TVEC;
      TVEC:    state_d = IDLE;
      EXIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Strobes are registered against the state they belong to
    case (state_d)
      ENTER: begin
        csr_we_d = 1'b1;
        enter_d  = 1'b1;
      end
      TVEC: begin
        redirect_d    = 1'b1;
        redirect_pc_d = MTVEC;
      end
      EXIT: begin
        exit_d        = 1'b1;
        redirect_d    = 1'b1;
        redirect_pc_d = mepc_i & PC_MASK;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      csr_we_q      <= 1'b0;
      enter_q       <= 1'b0;
      exit_q        <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      csr_we_q      <= csr_we_d;
      enter_q       <= enter_d;
      exit_q        <= exit_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      busy_q        <= busy_d;
    end
  end

  assign csr_we_o        = csr_we_q;
  assign mepc_o          = mepc_q;
  assign mcause_o        = mcause_q;
  assign mtval_o         = mtval_q;
  assign mstatus_enter_o = enter_q;
  assign mstatus_exit_o  = exit_q;
  assign redirect_o      = redirect_q;
  assign redirect_pc_o   = redirect_pc_q;
  assign busy_o          = busy_q;
endmodule

// File: tb/tb_riscv_trap_ctrl.sv
// Self-checking bench for riscv_trap_ctrl: directed scenarios plus a
// randomized run checked against an event-level reference model.
module tb_riscv_trap_ctrl;
  localparam logic [31:0] MTVEC = 32'h8000_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid, boundary, mret, meip, mtip, mie, meie, mtie;
  logic [31:0] exc_cause, exc_pc, exc_tval, next_pc, mepc_in;
  logic        stall_o, csr_we_o, mstatus_enter_o, mstatus_exit_o, redirect_o, busy_o;
  logic [31:0] mepc_o, mcause_o, mtval_o, redirect_pc_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_mepc, m_mcause, m_mtval;

  riscv_trap_ctrl #(.MTVEC(MTVEC)) dut (
    .clk(clk), .rst(rst),
    .exc_valid_i(exc_valid), .exc_cause_i(exc_cause), .exc_pc_i(exc_pc),
    .exc_tval_i(exc_tval), .boundary_i(boundary), .next_pc_i(next_pc),
    .mret_i(mret), .meip_i(meip), .mtip_i(mtip), .mstatus_mie_i(mie),
    .meie_i(meie), .mtie_i(mtie), .mepc_i(mepc_in),
    .stall_o(stall_o), .csr_we_o(csr_we_o), .mepc_o(mepc_o), .mcause_o(mcause_o),
    .mtval_o(mtval_o), .mstatus_enter_o(mstatus_enter_o),
    .mstatus_exit_o(mstatus_exit_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    exc_valid = 0; boundary = 0; mret = 0; meip = 0; mtip = 0;
    mie = 0; meie = 0; mtie = 0;
    exc_cause = 0; exc_pc = 0; exc_tval = 0; next_pc = 0; mepc_in = 0;
  endtask

  // {csr_we, enter, exit, redirect, busy, stall}
  function automatic logic [5:0] strobes();
    return {csr_we_o, mstatus_enter_o, mstatus_exit_o, redirect_o, busy_o, stall_o};
  endfunction

  // Reference: 0 none, 1 exception, 2 mret, 3 external irq, 4 timer irq
  function automatic int ref_kind();
    if (exc_valid) return 1;
    if (mret) return 2;
    if (boundary && mie && meie && meip) return 3;
    if (boundary && mie && mtie && mtip) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] ref_mtval(input logic [31:0] cause, input logic [31:0] pc,
                                            input logic [31:0] tval);
    if (cause == 32'd3) return pc;
    if (cause == 32'd11) return 32'h0;
    return tval;
  endfunction

  task automatic test_reset;
    clear_inputs();
    rst = 1;
    tick(); tick();
    tests++; if (strobes() !== 6'b0) begin fails++; $display("FAIL reset_strobes got %b exp 000000", strobes()); end
    tests++; if ({mepc_o, mcause_o, mtval_o, redirect_pc_o} !== 128'h0) begin
      fails++; $display("FAIL reset_regs got %h %h %h %h exp zeros", mepc_o, mcause_o, mtval_o, redirect_pc_o);
    end
    rst = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0;
    tick();
  endtask

  task automatic test_illegal;
    clear_inputs();
    exc_valid = 1; exc_cause = 2; exc_pc = 32'h8000_0100; exc_tval = 32'hFFFF_FFFF;
    #1;
    tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL ill_stall_accept got %b exp 1", stall_o); end
    tick(); clear_inputs();
    tests++; if (strobes() !== 6'b110011) begin fails++; $display("FAIL ill_enter_strobes got %b exp 110011", strobes()); end
    tests++; if ({mepc_o, mcause_o, mtval_o} !== {32'h8000_0100, 32'd2, 32'hFFFF_FFFF}) begin
      fails++; $display("FAIL ill_capture got %h %h %h exp 80000100 00000002 ffffffff", mepc_o, mcause_o, mtval_o);
    end
    m_mepc = 32'h8000_0100; m_mcause = 2; m_mtval = 32'hFFFF_FFFF;
    tick();
    tests++; if (strobes() !== 6'b000111) begin fails++; $display("FAIL ill_tvec_strobes got %b exp 000111", strobes()); end
    tests++; if (redirect_pc_o !== MTVEC) begin fails++; $display("FAIL ill_tvec_pc got %h exp %h", redirect_pc_o, MTVEC); end
    tick();
    tests++; if (strobes() !== 6'b0) begin fails++; $display("FAIL ill_idle got %b exp 000000", strobes()); end
  endtask

  task automatic test_ext_irq;
    clear_inputs();
    meip = 1; meie = 1; mie = 0; boundary = 1; next_pc = 32'h8000_0204;
    #1;
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL ext_masked_stall got %b exp 0", stall_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (busy_o !== 1'b0 || csr_we_o !== 1'b0) begin
        fails++; $display("FAIL ext_masked_busy got busy=%b we=%b exp 0 0", busy_o, csr_we_o);
      end
    end
    mie = 1;
    #1;
    tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL ext_stall_accept got %b exp 1", stall_o); end
    tick(); clear_inputs();
    tests++; if (strobes() !== 6'b110011) begin fails++; $display("FAIL ext_enter_strobes got %b exp 110011", strobes()); end
    tests++; if ({mepc_o, mcause_o, mtval_o} !== {32'h8000_0204, 32'h8000_000B, 32'h0}) begin
      fails++; $display("FAIL ext_capture got %h %h %h exp 80000204 8000000b 00000000", mepc_o, mcause_o, mtval_o);
    end
    m_mepc = 32'h8000_0204; m_mcause = 32'h8000_000B; m_mtval = 0;
    tick(); tick();
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL ext_idle got busy=%b exp 0", busy_o); end
  endtask

  task automatic test_priority;
    clear_inputs();
    exc_valid = 1; exc_cause = 11; exc_pc = 32'h8000_0300; exc_tval = 32'h0000_1234;
    meip = 1; meie = 1; mie = 1; boundary = 1; mret = 1; mepc_in = 32'h8000_0500;
    tick(); clear_inputs();
    tests++; if (strobes() !== 6'b110011) begin fails++; $display("FAIL prio_exc_strobes got %b exp 110011", strobes()); end
    tests++; if ({mepc_o, mcause_o, mtval_o} !== {32'h8000_0300, 32'd11, 32'h0}) begin
      fails++; $display("FAIL prio_exc_capture got %h %h %h exp 80000300 0000000b 00000000", mepc_o, mcause_o, mtval_o);
    end
    tick();
    tests++; if (mstatus_exit_o !== 1'b0 || redirect_pc_o !== MTVEC) begin
      fails++; $display("FAIL prio_no_mret got exit=%b pc=%h exp 0 %h", mstatus_exit_o, redirect_pc_o, MTVEC);
    end
    tick();
    // both interrupts pending: external first, timer on the next boundary
    meip = 1; mtip = 1; meie = 1; mtie = 1; mie = 1; boundary = 1; next_pc = 32'h8000_0400;
    tick();
    tests++; if (mcause_o !== 32'h8000_000B) begin fails++; $display("FAIL prio_ext_first got %h exp 8000000b", mcause_o); end
    meip = 0;
    tick(); tick();
    tests++; if (stall_o !== 1'b1 || busy_o !== 1'b0) begin
      fails++; $display("FAIL prio_tmr_accept got stall=%b busy=%b exp 1 0", stall_o, busy_o);
    end
    tick(); clear_inputs();
    tests++; if ({mepc_o, mcause_o, mtval_o} !== {32'h8000_0400, 32'h8000_0007, 32'h0}) begin
      fails++; $display("FAIL prio_tmr_capture got %h %h %h exp 80000400 80000007 00000000", mepc_o, mcause_o, mtval_o);
    end
    m_mepc = 32'h8000_0400; m_mcause = 32'h8000_0007; m_mtval = 0;
    tick(); tick();
  endtask

  task automatic test_mret;
    clear_inputs();
    mret = 1; mepc_in = 32'h8000_0041;
    #1;
    tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL mret_stall_accept got %b exp 1", stall_o); end
    tick();
    mret = 0;
    tests++; if (strobes() !== 6'b001111) begin fails++; $display("FAIL mret_exit_strobes got %b exp 001111", strobes()); end
    tests++; if (redirect_pc_o !== 32'h8000_0040) begin fails++; $display("FAIL mret_pc got %h exp 80000040", redirect_pc_o); end
    tests++; if (mepc_o !== m_mepc) begin fails++; $display("FAIL mret_mepc_hold got %h exp %h", mepc_o, m_mepc); end
    tick();
    tests++; if (strobes() !== 6'b0) begin fails++; $display("FAIL mret_idle got %b exp 000000", strobes()); end
  endtask

  task automatic test_reset_mid;
    clear_inputs();
    exc_valid = 1; exc_cause = 5; exc_pc = 32'h8000_0600; exc_tval = 32'hDEAD_BEEF;
    tick();
    tests++; if (csr_we_o !== 1'b1) begin fails++; $display("FAIL rmid_enter got we=%b exp 1", csr_we_o); end
    rst = 1; clear_inputs();
    tick();
    tests++; if (strobes() !== 6'b0 || {mepc_o, mcause_o, mtval_o, redirect_pc_o} !== 128'h0) begin
      fails++; $display("FAIL rmid_abort got %b %h %h %h %h exp zeros", strobes(), mepc_o, mcause_o, mtval_o, redirect_pc_o);
    end
    rst = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0;
    tick();
    tests++; if (redirect_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL rmid_no_redirect got redir=%b busy=%b exp 0 0", redirect_o, busy_o);
    end
    exc_valid = 1; exc_cause = 1; exc_pc = 32'h8000_0700; exc_tval = 32'h8000_0701;
    tick(); clear_inputs();
    tests++; if ({mepc_o, mcause_o, mtval_o} !== {32'h8000_0700, 32'd1, 32'h8000_0701} || strobes() !== 6'b110011) begin
      fails++; $display("FAIL rmid_fresh got %h %h %h %b exp 80000700 00000001 80000701 110011", mepc_o, mcause_o, mtval_o, strobes());
    end
    m_mepc = 32'h8000_0700; m_mcause = 1; m_mtval = 32'h8000_0701;
    tick();
    tests++; if (redirect_o !== 1'b1 || redirect_pc_o !== MTVEC) begin
      fails++; $display("FAIL rmid_fresh_tvec got %b %h exp 1 %h", redirect_o, redirect_pc_o, MTVEC);
    end
    tick();
  endtask

  task automatic test_stall_hold;
    clear_inputs();
    exc_valid = 1; exc_cause = 3; exc_pc = 32'h8000_0800; exc_tval = 32'h5555_5555;
    tick();
    tests++; if (stall_o !== 1'b1 || mtval_o !== 32'h8000_0800) begin
      fails++; $display("FAIL hold_enter got stall=%b mtval=%h exp 1 80000800", stall_o, mtval_o);
    end
    exc_cause = 4; exc_pc = 32'h8000_0900; exc_tval = 32'h0000_0A0A;
    tick();
    tests++; if (stall_o !== 1'b1 || csr_we_o !== 1'b0 || mepc_o !== 32'h8000_0800) begin
      fails++; $display("FAIL hold_tvec got stall=%b we=%b mepc=%h exp 1 0 80000800", stall_o, csr_we_o, mepc_o);
    end
    tick();
    tests++; if (stall_o !== 1'b1 || busy_o !== 1'b0) begin
      fails++; $display("FAIL hold_idle_accept got stall=%b busy=%b exp 1 0", stall_o, busy_o);
    end
    tick(); clear_inputs();
    tests++; if ({mepc_o, mcause_o, mtval_o} !== {32'h8000_0900, 32'd4, 32'h0000_0A0A}) begin
      fails++; $display("FAIL hold_second got %h %h %h exp 80000900 00000004 00000a0a", mepc_o, mcause_o, mtval_o);
    end
    m_mepc = 32'h8000_0900; m_mcause = 4; m_mtval = 32'h0000_0A0A;
    tick(); tick();
  endtask

  task automatic test_random;
    logic [31:0] causes [9] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd11};
    logic [31:0] e_mepc, e_cause, e_tval;
    int k;
    for (int it = 0; it < 300; it++) begin
      exc_valid = ($urandom_range(0, 3) == 0);
      mret      = ($urandom_range(0, 3) == 0);
      boundary  = 1'($urandom_range(0, 1));
      meip = 1'($urandom_range(0, 1)); mtip = 1'($urandom_range(0, 1));
      mie  = 1'($urandom_range(0, 1)); meie = 1'($urandom_range(0, 1)); mtie = 1'($urandom_range(0, 1));
      exc_cause = causes[$urandom_range(0, 8)];
      exc_pc = $urandom; exc_tval = $urandom; next_pc = $urandom; mepc_in = $urandom;
      k = ref_kind();
      e_mepc = m_mepc; e_cause = m_mcause; e_tval = m_mtval;
      case (k)
        1: begin e_mepc = {exc_pc[31:1], 1'b0}; e_cause = exc_cause; e_tval = ref_mtval(exc_cause, exc_pc, exc_tval); end
        3: begin e_mepc = {next_pc[31:1], 1'b0}; e_cause = 32'h8000_000B; e_tval = 0; end
        4: begin e_mepc = {next_pc[31:1], 1'b0}; e_cause = 32'h8000_0007; e_tval = 0; end
        default: ;
      endcase
      #1;
      tests++; if (stall_o !== (k != 0)) begin fails++; $display("FAIL rnd_stall it=%0d got %b exp %b", it, stall_o, k != 0); end
      tick();
      if (k == 0) begin
        tests++; if (strobes() !== {5'b0, stall_o} || {mepc_o, mcause_o, mtval_o} !== {m_mepc, m_mcause, m_mtval}) begin
          fails++; $display("FAIL rnd_none it=%0d got %b %h %h %h", it, strobes(), mepc_o, mcause_o, mtval_o);
        end
      end else if (k == 2) begin
        tests++; if (strobes() !== 6'b001111 || redirect_pc_o !== {mepc_in[31:1], 1'b0}) begin
          fails++; $display("FAIL rnd_mret it=%0d got %b %h exp 001111 %h", it, strobes(), redirect_pc_o, {mepc_in[31:1], 1'b0});
        end
        clear_inputs();
        tick();
        tests++; if (strobes() !== 6'b0) begin fails++; $display("FAIL rnd_mret_idle it=%0d got %b exp 000000", it, strobes()); end
      end else begin
        tests++; if (strobes() !== 6'b110011 || {mepc_o, mcause_o, mtval_o} !== {e_mepc, e_cause, e_tval}) begin
          fails++; $display("FAIL rnd_trap it=%0d kind=%0d got %b %h %h %h exp 110011 %h %h %h",
                            it, k, strobes(), mepc_o, mcause_o, mtval_o, e_mepc, e_cause, e_tval);
        end
        m_mepc = e_mepc; m_mcause = e_cause; m_mtval = e_tval;
        exc_valid = 1'($urandom_range(0, 1)); exc_pc = $urandom; exc_cause = causes[$urandom_range(0, 8)];
        tick();
        tests++; if (strobes() !== 6'b000111 || redirect_pc_o !== MTVEC || mepc_o !== m_mepc) begin
          fails++; $display("FAIL rnd_tvec it=%0d got %b %h %h exp 000111 %h %h", it, strobes(), redirect_pc_o, mepc_o, MTVEC, m_mepc);
        end
        clear_inputs();
        tick();
        tests++; if (strobes() !== 6'b0) begin fails++; $display("FAIL rnd_trap_idle it=%0d got %b exp 000000", it, strobes()); end
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_illegal();
    test_ext_irq();
    test_priority();
    test_mret();
    test_reset_mid();
    test_stall_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
